packet_trigger: RTL

Parametrised detection and framing back-end of the receive synchronizer. It consumes the aligned per-sample stream of baseband sample, CORDIC magnitude, window energy and phase-derived frequency. It compares magnitude against a runtime-programmable fraction of energy, debounces the trigger, and frames packets with first/last markers, a frozen frequency-offset estimate and a maximum-length guard. An optional gating mode discards samples outside packets.

---
 rtl/packet_trigger.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/packet_trigger.sv
// Packet detection back-end: compares magnitude against a programmable fraction of
// energy, debounces the trigger and frames packets with first/last markers.
module packet_trigger #(
  parameter int WIDTH        = 16,
  parameter int METRIC_WIDTH = 32,
  parameter int HOLD         = 29,
  parameter int MAX_LENGTH   = 4096,
  parameter int MAG_SHIFT    = 1,
  parameter int FREQ_SHIFT   = 4,
  parameter int GATE         = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [2*WIDTH-1:0]      s_data,
  input  logic [METRIC_WIDTH-1:0] s_magnitude,
  input  logic [METRIC_WIDTH-1:0] s_energy,
  input  logic [METRIC_WIDTH-1:0] s_frequency,
  input  logic [7:0]              cfg_threshold,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*WIDTH-1:0]      m_data,
  output logic [METRIC_WIDTH-1:0] m_user,
  output logic                    m_first,
  output logic                    m_last,
  output logic                    detected
);

  localparam int RUN_W  = $clog2(HOLD + 1);
  localparam int LEN_W  = $clog2(MAX_LENGTH + 1);
  localparam int PROD_W = METRIC_WIDTH + 9;

  typedef enum logic [1:0] {SEARCH, ACTIVE, BLANK} state_t;

  state_t                   state_q, state_d;
  logic                     p_valid_q, p_valid_d;
  logic [2*WIDTH-1:0]       p_data_q, p_data_d;
  logic [METRIC_WIDTH-1:0]  p_freq_q, p_freq_d;
  logic                     p_trig_q, p_trig_d;
  logic [RUN_W-1:0]         run_q, run_d;
  logic                     prev_q, prev_d;
  logic [LEN_W-1:0]         len_q, len_d;
  logic [METRIC_WIDTH-1:0]  user_q, user_d;

  logic signed [METRIC_WIDTH-1:0] mag_shifted;
  logic signed [METRIC_WIDTH-1:0] freq_shifted;
  logic signed [PROD_W-1:0]       mag_ext, energy_ext, thr_ext, product, scaled;
  logic                           trig_in;

  // Full-width signed product so large negative energies cannot wrap the threshold.
  always_comb begin
    mag_shifted  = $signed(s_magnitude) >>> MAG_SHIFT;
    freq_shifted = $signed(s_frequency) >>> FREQ_SHIFT;
    mag_ext      = {{9{mag_shifted[METRIC_WIDTH-1]}}, mag_shifted};
    energy_ext   = {{9{s_energy[METRIC_WIDTH-1]}}, s_energy};
    thr_ext      = {{(METRIC_WIDTH+1){1'b0}}, cfg_threshold};
    product      = energy_ext * thr_ext;
    scaled       = product >>> 8;
    trig_in      = mag_ext > scaled;
  end

  logic is_active, t_eq, stable, stable_high, stable_low, len_at_max;
  logic drop, consume, load;

  always_comb begin
    is_active   = state_q == ACTIVE;
    t_eq        = p_trig_q == prev_q;
    stable      = t_eq && (run_q == RUN_W'(HOLD - 1));
    stable_high = stable && p_trig_q;
    stable_low  = stable && !p_trig_q;
    len_at_max  = len_q == LEN_W'(MAX_LENGTH - 1);

    m_valid  = p_valid_q && ((GATE == 0) || is_active);
    drop     = p_valid_q && (GATE != 0) && !is_active;
    consume  = (m_valid && m_ready) || drop;
    s_ready  = !p_valid_q || consume;
    load     = s_valid && s_ready;

    m_first  = is_active && (len_q == '0) && p_valid_q;
    m_last   = p_valid_q && is_active && (stable_low || len_at_max);
    m_data   = p_data_q;
    m_user   = user_q;
    detected = is_active;
  end

  always_comb begin
    p_valid_d = p_valid_q;
    p_data_d  = p_data_q;
    p_freq_d  = p_freq_q;
    p_trig_d  = p_trig_q;
    state_d   = state_q;
    run_d     = run_q;
    prev_d    = prev_q;
    len_d     = len_q;
    user_d    = user_q;

    if (load) begin
      p_valid_d = 1'b1;
      p_data_d  = s_data;
      p_freq_d  = freq_shifted;
      p_trig_d  = trig_in;
    end else if (consume) begin
      p_valid_d = 1'b0;
    end

    // Debounce and framing advance only on entries that actually leave the stage.
    if (consume) begin
      prev_d = p_trig_q;
      if (!t_eq)
        run_d = RUN_W'(1);
      else if (run_q != RUN_W'(HOLD))
        run_d = run_q + RUN_W'(1);

      case (state_q)
        SEARCH: begin
          user_d = p_freq_q;
          if (stable_high) begin
            state_d = ACTIVE;
            len_d   = '0;
          end
        end
        ACTIVE: begin
          len_d = len_q + LEN_W'(1);
          if (stable_low)
            state_d = SEARCH;
          else if (len_at_max)
            state_d = BLANK;
        end
        BLANK: begin
          if (stable_low)
            state_d = SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid_q <= 1'b0;
      p_data_q  <= '0;
      p_freq_q  <= '0;
      p_trig_q  <= 1'b0;
      state_q   <= SEARCH;
      run_q     <= RUN_W'(HOLD);
      prev_q    <= 1'b0;
      len_q     <= '0;
      user_q    <= '0;
    end else begin
      p_valid_q <= p_valid_d;
      p_data_q  <= p_data_d;
      p_freq_q  <= p_freq_d;
      p_trig_q  <= p_trig_d;
      state_q   <= state_d;
      run_q     <= run_d;
      prev_q    <= prev_d;
      len_q     <= len_d;
      user_q    <= user_d;
    end
  end

endmodule
